// File: rtl/load_ext_unit_pkg.sv
// Shared load/store select codes, FSM state encoding and the load alignment rule
// used by the M-stage load unit.
package load_ext_unit_pkg;

  localparam logic [2:0] L_LW  = 3'b000;
  localparam logic [2:0] L_LH  = 3'b001;
  localparam logic [2:0] L_LHU = 3'b010;
  localparam logic [2:0] L_LB  = 3'b011;
  localparam logic [2:0] L_LBU = 3'b100;

  localparam logic [1:0] S_SW = 2'b00;
  localparam logic [1:0] S_SH = 2'b01;
  localparam logic [1:0] S_SB = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Undefined select codes behave as LW, so they need full word alignment.
  function automatic logic is_misaligned(input logic [2:0] sel, input logic [1:0] lane);
    case (sel)
      L_LH, L_LHU: return lane[0];
      L_LB, L_LBU: return 1'b0;
      default:     return lane != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_ext_unit_ext.sv
// Combinational lane select and sign/zero extension of a little-endian memory word.
module load_ext
  import load_ext_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  l_sel,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (lane)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = lane[1] ? rdata[31:16] : rdata[15:0];

    case (l_sel)
      L_LH:    result = {{16{half_v[15]}}, half_v};
      L_LHU:   result = {16'h0000, half_v};
      L_LB:    result = {{24{byte_v[7]}}, byte_v};
      L_LBU:   result = {24'h000000, byte_v};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/load_ext_unit.sv
// M-stage load unit: issues a word-aligned read over req/ack, stalls while waiting,
// and delivers one extended, registered result (or an AdEL / timeout pulse).
module load_ext_unit
  import load_ext_unit_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        L_SEL,
  input  logic [4:0]        rd_tag,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              stall,
  output logic              wb_valid,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_tag,
  output logic              adel,
  output logic              bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        lane_q, lane_d;
  logic [2:0]        sel_q, sel_d;
  logic [4:0]        tag_q, tag_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              wb_valid_q, wb_valid_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic [4:0]        wb_tag_q, wb_tag_d;
  logic              adel_q, adel_d;
  logic              bus_err_q, bus_err_d;
  logic [31:0]       ext_result;

  logic issue, reject, done, timeout_hit;

  assign issue       = (state_q == ST_IDLE) && ld_valid && !is_misaligned(L_SEL, addr[1:0]);
  assign reject      = (state_q == ST_IDLE) && ld_valid &&  is_misaligned(L_SEL, addr[1:0]);
  assign done        = (state_q == ST_WAIT) && mem_ack;
  // An ack arriving on the last allowed cycle still completes the load.
  assign timeout_hit = (state_q == ST_WAIT) && !mem_ack && (cnt_q == CNT_W'(TIMEOUT - 1));

  load_ext u_ext (
    .rdata  (mem_rdata),
    .lane   (lane_q),
    .l_sel  (sel_q),
    .result (ext_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (issue) state_d = ST_WAIT;
      ST_WAIT: if (done || timeout_hit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    lane_d     = lane_q;
    sel_d      = sel_q;
    tag_d      = tag_q;
    mem_addr_d = mem_addr_q;
    wb_data_d  = wb_data_q;
    wb_tag_d   = wb_tag_q;
    mem_req_d  = issue || ((state_q == ST_WAIT) && !done && !timeout_hit);
    wb_valid_d = done;
    adel_d     = reject;
    bus_err_d  = timeout_hit;
    if (issue) begin
      cnt_d      = '0;
      lane_d     = addr[1:0];
      sel_d      = L_SEL;
      tag_d      = rd_tag;
      mem_addr_d = {addr[ADDR_W-1:2], 2'b00};
    end else if ((state_q == ST_WAIT) && !mem_ack) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (done) begin
      wb_data_d = ext_result;
      wb_tag_d  = tag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      lane_q     <= '0;
      sel_q      <= '0;
      tag_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_tag_q   <= '0;
      adel_q     <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      lane_q     <= lane_d;
      sel_q      <= sel_d;
      tag_q      <= tag_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_tag_q   <= wb_tag_d;
      adel_q     <= adel_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign stall    = (state_q == ST_WAIT) || issue;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_data_q;
  assign wb_tag   = wb_tag_q;
  assign adel     = adel_q;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_load_ext_unit.sv
// Bench for load_ext_unit: directed literal cases plus randomized traffic checked
// every cycle against a transaction-level reference model.
module tb_load_ext_unit;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;
  localparam logic [2:0] C_LW = 3'd0, C_LH = 3'd1, C_LHU = 3'd2, C_LB = 3'd3, C_LBU = 3'd4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ld_valid = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [2:0]        L_SEL = '0;
  logic [4:0]        rd_tag = '0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [31:0]       mem_rdata = '0;
  logic              stall, wb_valid, adel, bus_err;
  logic [31:0]       wb_data;
  logic [4:0]        wb_tag;

  int n_tests = 0;
  int n_fail  = 0;

  load_ext_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .addr(addr), .L_SEL(L_SEL),
    .rd_tag(rd_tag), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_tag(wb_tag), .adel(adel), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules: alignment mask by access size, extraction by shifting the word.
  function automatic logic m_ok(input logic [2:0] sel, input logic [31:0] a);
    logic [31:0] mask;
    mask = (sel == C_LB || sel == C_LBU) ? 32'd0 : (sel == C_LH || sel == C_LHU) ? 32'd1 : 32'd3;
    return (a & mask) == 32'd0;
  endfunction

  function automatic logic [31:0] mext(input logic [31:0] w, input logic [2:0] sel, input logic [1:0] lane);
    logic [31:0] sh;
    sh = w >> (8 * lane);
    case (sel)
      C_LH:    return 32'($signed(sh[15:0]));
      C_LHU:   return {16'h0, sh[15:0]};
      C_LB:    return 32'($signed(sh[7:0]));
      C_LBU:   return {24'h0, sh[7:0]};
      default: return w;
    endcase
  endfunction

  logic        m_busy;
  int          m_age;
  logic [4:0]  m_tag;
  logic [2:0]  m_sel;
  logic [1:0]  m_lane;
  logic        e_req, e_wbv, e_adel, e_berr;
  logic [31:0] e_addr, e_wbd;
  logic [4:0]  e_tag;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_age <= 0; m_tag <= '0; m_sel <= '0; m_lane <= '0;
      e_req <= 1'b0; e_addr <= '0; e_wbv <= 1'b0; e_wbd <= '0; e_tag <= '0;
      e_adel <= 1'b0; e_berr <= 1'b0;
    end else begin
      e_wbv <= 1'b0; e_adel <= 1'b0; e_berr <= 1'b0;
      if (m_busy) begin
        if (mem_ack) begin
          e_wbv <= 1'b1; e_wbd <= mext(mem_rdata, m_sel, m_lane); e_tag <= m_tag;
          m_busy <= 1'b0; e_req <= 1'b0;
        end else if (m_age == TIMEOUT - 1) begin
          e_berr <= 1'b1; m_busy <= 1'b0; e_req <= 1'b0;
        end else begin
          m_age <= m_age + 1;
        end
      end else if (ld_valid) begin
        if (!m_ok(L_SEL, addr)) e_adel <= 1'b1;
        else begin
          m_busy <= 1'b1; m_age <= 0; e_req <= 1'b1; e_addr <= addr & ~32'd3;
          m_tag <= rd_tag; m_sel <= L_SEL; m_lane <= addr[1:0];
        end
      end
    end
  end

  always @(negedge clk) begin
    check("mdl_mem_req", {31'd0, mem_req}, {31'd0, e_req});
    check("mdl_mem_addr", mem_addr, e_addr);
    check("mdl_wb_valid", {31'd0, wb_valid}, {31'd0, e_wbv});
    check("mdl_wb_data", wb_data, e_wbd);
    check("mdl_wb_tag", {27'd0, wb_tag}, {27'd0, e_tag});
    check("mdl_adel", {31'd0, adel}, {31'd0, e_adel});
    check("mdl_bus_err", {31'd0, bus_err}, {31'd0, e_berr});
    check("mdl_stall", {31'd0, stall}, {31'd0, m_busy || (ld_valid && m_ok(L_SEL, addr))});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [2:0] sel, input logic [31:0] a, input logic [4:0] tag);
    ld_valid = 1'b1; L_SEL = sel; addr = a; rd_tag = tag;
  endtask

  int cnt;

  initial begin
    repeat (3) tick();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    rst_n = 1'b1;
    tick();

    // LB at byte 3 with immediate ack
    present(C_LB, 32'h1000_0003, 5'd7); #1;
    check("d1_stall_T", {31'd0, stall}, 32'd1);
    tick(); ld_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h80FF_1234; #1;
    check("d1_req_T1", {31'd0, mem_req}, 32'd1);
    check("d1_addr_T1", mem_addr, 32'h1000_0000);
    check("d1_stall_T1", {31'd0, stall}, 32'd1);
    tick(); mem_ack = 1'b0; #1;
    check("d1_wbv_T2", {31'd0, wb_valid}, 32'd1);
    check("d1_data_T2", wb_data, 32'hFFFF_FF80);
    check("d1_tag_T2", {27'd0, wb_tag}, 32'd7);
    check("d1_stall_T2", {31'd0, stall}, 32'd0);

    // LHU upper half, ack on the fifth request cycle
    present(C_LHU, 32'h2000_0002, 5'd12);
    tick(); ld_valid = 1'b0; cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      if (mem_req) cnt++;
      if (i == 5) begin mem_ack = 1'b1; mem_rdata = 32'hBEEF_0001; end
      tick();
    end
    mem_ack = 1'b0; #1;
    check("d2_req_cycles", cnt, 32'd5);
    check("d2_data", wb_data, 32'h0000_BEEF);
    check("d2_wbv", {31'd0, wb_valid}, 32'd1);

    // misaligned LW
    present(C_LW, 32'h3000_0002, 5'd3); #1;
    check("d3_stall", {31'd0, stall}, 32'd0);
    tick(); ld_valid = 1'b0; #1;
    check("d3_adel", {31'd0, adel}, 32'd1);
    check("d3_req", {31'd0, mem_req}, 32'd0);
    check("d3_wbv", {31'd0, wb_valid}, 32'd0);

    // LH with no ack: timeout, then a late ack is ignored
    present(C_LH, 32'h4000_0000, 5'd9);
    tick(); ld_valid = 1'b0; cnt = 0;
    for (int i = 0; i < 40 && mem_req; i++) begin cnt++; tick(); end
    check("d4_req_cycles", cnt, TIMEOUT);
    check("d4_bus_err", {31'd0, bus_err}, 32'd1);
    check("d4_req_low", {31'd0, mem_req}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick(); mem_ack = 1'b0; #1;
    check("d4_late_ack", {31'd0, wb_valid}, 32'd0);
    check("d4_stall", {31'd0, stall}, 32'd0);

    // back-to-back LW
    present(C_LW, 32'h5000_0004, 5'd1);
    tick(); ld_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    tick(); mem_ack = 1'b0; present(C_LW, 32'h5000_0008, 5'd2); #1;
    check("d5_wbv1", {31'd0, wb_valid}, 32'd1);
    check("d5_tag1", {27'd0, wb_tag}, 32'd1);
    check("d5_data1", wb_data, 32'h1111_1111);
    check("d5_stall_accept", {31'd0, stall}, 32'd1);
    tick(); ld_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
    tick(); mem_ack = 1'b0; #1;
    check("d5_wbv2", {31'd0, wb_valid}, 32'd1);
    check("d5_tag2", {27'd0, wb_tag}, 32'd2);
    check("d5_data2", wb_data, 32'h2222_2222);

    // asynchronous reset in WAIT, then a normal LBU
    present(C_LW, 32'h6000_0000, 5'd4);
    tick(); ld_valid = 1'b0; #1;
    check("d6_req_pre", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0; #1;
    check("d6_req_rst", {31'd0, mem_req}, 32'd0);
    check("d6_stall_rst", {31'd0, stall}, 32'd0);
    tick(); rst_n = 1'b1;
    tick(); present(C_LBU, 32'h7000_0001, 5'd21);
    tick(); ld_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_AB00;
    tick(); mem_ack = 1'b0; #1;
    check("d6_data", wb_data, 32'h0000_00AB);
    check("d6_tag", {27'd0, wb_tag}, 32'd21);

    // randomized traffic, with periodic silent-memory windows to force timeouts
    for (int c = 0; c < 1200; c++) begin
      tick();
      ld_valid  = ($urandom_range(0, 1) == 1);
      addr      = $urandom;
      L_SEL     = 3'($urandom_range(0, 7));
      rd_tag    = 5'($urandom);
      mem_rdata = $urandom;
      mem_ack   = ((c / 40) % 4 == 3) ? 1'b0 : ($urandom_range(0, 2) == 0);
    end
    tick();
    ld_valid = 1'b0; mem_ack = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
